// File: rtl/pg_monitor_mc_if.sv
// Bus bundle for the multi-channel power-good monitor: sampled rail codes in,
// per-channel status out.
interface pg_monitor_mc_if #(
    parameter int N_CH = 4,
    parameter int W    = 13
);
    logic [N_CH*W-1:0] vdd_i;
    logic              vdd_vld;
    logic [N_CH-1:0]   ov_clr;
    logic [N_CH-1:0]   pg;
    logic [N_CH-1:0]   ov;
    logic [N_CH-1:0]   ov_sticky;
    logic              all_pg;

    modport master (
        output vdd_i, vdd_vld, ov_clr,
        input  pg, ov, ov_sticky, all_pg
    );

    modport slave (
        input  vdd_i, vdd_vld, ov_clr,
        output pg, ov, ov_sticky, all_pg
    );
endinterface

// File: rtl/pg_monitor_mc.sv
// Multi-channel power-good monitor: per-rail UV hysteresis, qualification
// debounce, latched over-voltage and sticky OV flag, all on unsigned mV codes.
module pg_monitor_mc #(
    parameter int N_CH  = 4,
    parameter int W     = 13,
    parameter int TH_LO = 2900,
    parameter int TH_HI = 4100,
    parameter int HYST  = 50,
    parameter int DEB   = 4
) (
    input  logic          clk,
    input  logic          arst_n,
    pg_monitor_mc_if.slave bus
);

    if (!(TH_LO < TH_HI)) begin : g_bad_window
        $fatal(1, "pg_monitor_mc: TH_LO must be below TH_HI");
    end
    if (!(HYST < TH_LO)) begin : g_bad_hyst
        $fatal(1, "pg_monitor_mc: HYST must be below TH_LO");
    end
    if (TH_HI >= (1 << W)) begin : g_bad_range
        $fatal(1, "pg_monitor_mc: TH_HI does not fit in W bits");
    end
    if (DEB < 1 || DEB > 255) begin : g_bad_deb
        $fatal(1, "pg_monitor_mc: DEB must be in 1..255");
    end

    localparam logic [W-1:0] HI_C     = W'(TH_HI);
    localparam logic [W-1:0] LO_ON_C  = W'(TH_LO);
    localparam logic [W-1:0] LO_OFF_C = W'(TH_LO - HYST);
    localparam logic [7:0]   DEB_M1   = 8'(DEB - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_QUAL,
        ST_GOOD,
        ST_OV
    } state_e;

    logic [N_CH-1:0] pg_w;
    logic [N_CH-1:0] ov_w;
    logic [N_CH-1:0] sticky_w;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_e       state_q, state_d;
        logic [7:0]   cnt_q, cnt_d;
        logic         sticky_q, sticky_d;
        logic [W-1:0] v;
        logic         hi, lo_on, lo_off;

        assign v      = bus.vdd_i[k*W +: W];
        assign hi     = v > HI_C;
        assign lo_on  = v < LO_ON_C;
        assign lo_off = v < LO_OFF_C;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (bus.vdd_vld) begin
                if (hi) begin
                    state_d = ST_OV;
                    cnt_d   = '0;
                end else begin
                    unique case (state_q)
                        ST_OFF: begin
                            if (!lo_on) begin
                                state_d = (DEB == 1) ? ST_GOOD : ST_QUAL;
                                cnt_d   = 8'd1;
                            end
                        end
                        ST_QUAL: begin
                            if (lo_on) begin
                                state_d = ST_OFF;
                                cnt_d   = '0;
                            end else if (cnt_q == DEB_M1) begin
                                state_d = ST_GOOD;
                            end else begin
                                cnt_d = cnt_q + 8'd1;
                            end
                        end
                        ST_GOOD: begin
                            if (lo_off) begin
                                state_d = ST_OFF;
                                cnt_d   = '0;
                            end
                        end
                        ST_OV: begin
                            if (lo_on) begin
                                state_d = ST_OFF;
                                cnt_d   = '0;
                            end
                        end
                        default: begin
                            state_d = ST_OFF;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end
            // A new OV entry outranks a simultaneous clear.
            sticky_d = (sticky_q & ~bus.ov_clr[k])
                     | ((state_q != ST_OV) && (state_d == ST_OV));
        end

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                state_q  <= ST_OFF;
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                sticky_q <= sticky_d;
            end
        end

        assign pg_w[k]     = (state_q == ST_GOOD);
        assign ov_w[k]     = (state_q == ST_OV);
        assign sticky_w[k] = sticky_q;
    end

    assign bus.pg        = pg_w;
    assign bus.ov        = ov_w;
    assign bus.ov_sticky = sticky_w;
    assign bus.all_pg    = &pg_w;

endmodule
